// File: rtl/dram_arbiter.sv
// Two-port arbiter in front of the single DRAM/cache port: port 0 (memory stage) has
// fixed priority, port 1 (instruction refill) is force-granted after STARVE_LIMIT lost rounds.
module dram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        write_enable,
  output logic        read_enable,
  input  logic [31:0] rdata,
  input  logic        miss,
  output logic        busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] wait_cnt_r;
  logic [CW-1:0] wait_cnt_s;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic          we_r;
  logic          re_r;
  logic          grant0_s;
  logic          grant1_s;
  logic          done0_s;
  logic          done1_s;

  // Arbitration, starvation counting and completion detection.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    grant0_s   = 1'b0;
    grant1_s   = 1'b0;
    done0_s    = 1'b0;
    done1_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req1 && (wait_cnt_r == LIMIT_C)) begin
          grant1_s = 1'b1;
        end else if (req0) begin
          grant0_s = 1'b1;
        end else if (req1) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
        if (grant0_s) begin
          state_s = BUSY0;
        end else if (grant1_s) begin
          state_s = BUSY1;
        end else begin
          state_s = IDLE;
        end
        // Port 1 losing an arbitration it asked for counts toward its forced grant.
        if (grant1_s) begin
          wait_cnt_s = {CW{1'b0}};
        end else if (req1 && (wait_cnt_r != LIMIT_C)) begin
          wait_cnt_s = wait_cnt_r + CW'(1);
        end else begin
          wait_cnt_s = wait_cnt_r;
        end
      end
      BUSY0: begin
        if (!miss && !rst) begin
          done0_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = BUSY0;
        end
      end
      BUSY1: begin
        if (!miss && !rst) begin
          done1_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = BUSY1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, wait counter and the registered DRAM-side command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= {CW{1'b0}};
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      re_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (grant0_s) begin
        addr_r  <= addr0;
        wdata_r <= wdata0;
        we_r    <= we0;
        re_r    <= !we0;
      end else if (grant1_s) begin
        addr_r  <= addr1;
        wdata_r <= wdata1;
        we_r    <= we1;
        re_r    <= !we1;
      end else if (done0_s || done1_s) begin
        we_r <= 1'b0;
        re_r <= 1'b0;
      end else begin
        we_r <= we_r;
        re_r <= re_r;
      end
    end
  end

  assign addr         = addr_r;
  assign wdata        = wdata_r;
  assign write_enable = we_r;
  assign read_enable  = re_r;
  assign done0        = done0_s;
  assign done1        = done1_s;
  assign rdata0       = rdata;
  assign rdata1       = rdata;
  assign busy         = (state_r != IDLE);

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level ownership model plus a per-access scoreboard.
module tb_dram_arbiter;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] addr, wdata;
  logic        write_enable, read_enable;
  logic [31:0] rdata;
  logic        miss;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who owns the DRAM port (0 none, 1 port0, 2 port1), the command it drives,
  // and how many arbitrations port 1 has lost since it was last served.
  int          m_owner, m_loss;
  logic [31:0] m_addr, m_wdata;
  logic        m_we, m_re;
  logic        e_d0, e_d1;
  int          done_log[$];

  always #5 clk = ~clk;

  dram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .addr(addr), .wdata(wdata), .write_enable(write_enable), .read_enable(read_enable),
    .rdata(rdata), .miss(miss), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: compare DUT outputs with the model and score completed accesses.
  task automatic settle();
    @(negedge clk);
    e_d0 = !rst && (m_owner == 1) && !miss;
    e_d1 = !rst && (m_owner == 2) && !miss;
    chk("ctl", {27'd0, busy, write_enable, read_enable, done0, done1},
        {27'd0, (m_owner != 0), m_we, m_re, e_d0, e_d1});
    chk("addr", addr, m_addr);
    chk("wdata", wdata, m_wdata);
    chk("rdata0", rdata0, rdata);
    chk("rdata1", rdata1, rdata);
    chk("excl", {31'd0, write_enable & read_enable}, 32'd0);
    if (e_d0) begin
      chk("sb0_req", {31'd0, req0}, 32'd1);
      chk("sb0_addr", addr, addr0);
      chk("sb0_we", {31'd0, write_enable}, {31'd0, we0});
      if (we0) chk("sb0_wdata", wdata, wdata0);
    end
    if (e_d1) begin
      chk("sb1_req", {31'd0, req1}, 32'd1);
      chk("sb1_addr", addr, addr1);
      chk("sb1_we", {31'd0, write_enable}, {31'd0, we1});
      if (we1) chk("sb1_wdata", wdata, wdata1);
    end
    if (done0) done_log.push_back(0);
    if (done1) done_log.push_back(1);
  endtask

  // Apply the arbitration rules to the current inputs, then cross the clock edge.
  task automatic advance();
    int          w, n_owner, n_loss;
    logic [31:0] n_addr, n_wdata;
    logic        n_we, n_re;
    n_owner = m_owner; n_loss = m_loss; n_addr = m_addr; n_wdata = m_wdata;
    n_we = m_we; n_re = m_re; w = 0;
    if (rst) begin
      n_owner = 0; n_loss = 0; n_addr = 32'd0; n_wdata = 32'd0; n_we = 1'b0; n_re = 1'b0;
    end else if (m_owner == 0) begin
      if (req1 && m_loss == LIMIT) w = 2;
      else if (req0) w = 1;
      else if (req1) w = 2;
      if (w == 1) begin
        n_owner = 1; n_addr = addr0; n_wdata = wdata0; n_we = we0; n_re = !we0;
      end
      if (w == 2) begin
        n_owner = 2; n_addr = addr1; n_wdata = wdata1; n_we = we1; n_re = !we1;
      end
      if (w == 2) n_loss = 0;
      else if (req1) n_loss = (m_loss < LIMIT) ? m_loss + 1 : LIMIT;
    end else if (!miss) begin
      n_owner = 0; n_we = 1'b0; n_re = 1'b0;
    end
    @(posedge clk);
    #1;
    m_owner = n_owner; m_loss = n_loss; m_addr = n_addr; m_wdata = n_wdata;
    m_we = n_we; m_re = n_re;
    rdata = $urandom;
  endtask

  task automatic new_access(input int k);
    if (k == 0) begin
      req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = $urandom; wdata0 = $urandom;
    end else begin
      req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = $urandom; wdata1 = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
  endtask

  // Finish outstanding accesses with miss low; requesters drop after their done.
  task automatic drain();
    miss = 1'b0;
    for (int c = 0; c < 40 && (req0 || req1); c++) begin
      settle();
      advance();
      if (e_d0) req0 = 1'b0;
      if (e_d1) req1 = 1'b0;
    end
    chk("drain", {30'd0, req0, req1}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'd0; addr1 = 32'd0; wdata0 = 32'd0; wdata1 = 32'd0;
    rdata = 32'h1234_5678; miss = 1'b0;
    m_owner = 0; m_loss = 0; m_addr = 32'd0; m_wdata = 32'd0; m_we = 1'b0; m_re = 1'b0;
    #1;
    do_reset();
    settle();
    chk("rst_state", {28'd0, busy, write_enable, read_enable, done0}, 32'd0);
    advance();

    // Single read on port 0 with a hit.
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100; wdata0 = 32'h0;
    settle(); advance();
    settle();
    chk("t1_re", {31'd0, read_enable}, 32'd1);
    chk("t1_addr", addr, 32'h100);
    chk("t1_done0", {31'd0, done0}, 32'd1);
    advance();
    req0 = 1'b0;
    settle();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    advance();

    // Port 1 write held off by three miss cycles.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2000; wdata1 = 32'hDEADBEEF;
    settle(); advance();
    for (int i = 0; i < 4; i++) begin
      miss = (i < 3);
      settle();
      chk("t2_we", {31'd0, write_enable}, 32'd1);
      chk("t2_done", {30'd0, done0, done1}, (i == 3) ? 32'd1 : 32'd0);
      chk("t2_wdata", wdata, 32'hDEADBEEF);
      advance();
    end
    req1 = 1'b0; miss = 1'b0;
    settle(); advance();

    // Both ports requesting continuously: eight port-0 grants, then one forced port-1 grant.
    done_log.delete();
    new_access(0); new_access(1);
    for (int c = 0; c < 100 && done_log.size() < 18; c++) begin
      settle(); advance();
      if (e_d0) begin
        if (done_log.size() < 18) new_access(0); else req0 = 1'b0;
      end
      if (e_d1) begin
        if (done_log.size() < 18) new_access(1); else req1 = 1'b1 & 1'b0;
      end
    end
    drain();
    chk("t3_cnt", {31'd0, done_log.size() >= 18}, 32'd1);
    for (int i = 0; i < 18 && i < done_log.size(); i++)
      chk("t3_order", 32'(done_log[i]), (i % 9 == 8) ? 32'd1 : 32'd0);

    // Simultaneous requests with an empty wait counter: port 0 first, then port 1.
    do_reset();
    done_log.delete();
    new_access(0); new_access(1);
    drain();
    chk("t4_cnt", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) begin
      chk("t4_first", 32'(done_log[0]), 32'd0);
      chk("t4_second", 32'(done_log[1]), 32'd1);
    end

    // Reset in the middle of a stalled port-1 access, then a normal port-0 read.
    do_reset();
    new_access(1); we1 = 1'b0; miss = 1'b1;
    settle(); advance();
    settle();
    chk("t5_busy", {31'd0, busy}, 32'd1);
    advance();
    rst = 1'b1;
    settle();
    chk("t5_nodone", {31'd0, done1}, 32'd0);
    advance();
    rst = 1'b0; req1 = 1'b0;
    settle();
    chk("t5_after", {28'd0, busy, write_enable, read_enable, done1}, 32'd0);
    advance();
    new_access(0); we0 = 1'b0; miss = 1'b0;
    settle(); advance();
    settle();
    chk("t5_p0done", {31'd0, done0}, 32'd1);
    advance();
    req0 = 1'b0;

    // Random traffic.
    for (int c = 0; c < 10000; c++) begin
      settle(); advance();
      if (e_d0) begin
        if ($urandom_range(0, 1) == 1) new_access(0); else req0 = 1'b0;
      end else if (!req0 && $urandom_range(0, 3) == 0) begin
        new_access(0);
      end
      if (e_d1) begin
        if ($urandom_range(0, 1) == 1) new_access(1); else req1 = 1'b0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        new_access(1);
      end
      miss = ($urandom_range(0, 2) == 0);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
